// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding CPU data access to a one-port word memory.
// Sub-word stores are read-modify-write; misaligned/out-of-range requests fail without touching memory.
module load_store_unit #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t             state;
    logic               we_q;
    logic               uns_q;
    logic [1:0]         size_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q;

    logic               req_err;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        load_val;
    logic [31:0]        store_val;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (|(req_addr >> (IDX_W + 2)))
            req_err = 1'b1;
    end

    // Little-endian lane pick and extension of the captured memory word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_rd[7:0];
            2'd1:    lane_b = mem_rd[15:8];
            2'd2:    lane_b = mem_rd[23:16];
            default: lane_b = mem_rd[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_rd;
        endcase
    end

    always_comb begin
        store_val = mem_rd;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    store_val[7:0]   = wdata_q[7:0];
                    2'd1:    store_val[15:8]  = wdata_q[7:0];
                    2'd2:    store_val[23:16] = wdata_q[7:0];
                    default: store_val[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) store_val[31:16] = wdata_q[15:0];
                else           store_val[15:0]  = wdata_q[15:0];
            end
            default: store_val = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= req_addr[IDX_W+1:0];
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            merge_q <= req_wdata;
                            state   <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD:   state <= CAP;
                CAP: begin
                    if (we_q) begin
                        merge_q <= store_val;
                        state   <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign mem_memread  = (state == RD);
    assign mem_memwrite = (state == WR);
    assign mem_addr     = 7'(addr_q[IDX_W+1:2]);
    assign mem_wd       = merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: behavioural word memory, shadow model of expected contents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wd;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_rd = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
        logic [6:0]  idx;
    } exp_t;
    exp_t sb[$];

    logic [31:0] tmem [0:127];
    logic [31:0] smem [0:127];

    load_store_unit #(.IDX_W(6)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memwrite) tmem[mem_addr] <= mem_wd;
        if (mem_memread)  mem_rd <= tmem[mem_addr];
    end

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (off * 8));
        h = 16'(w >> (off * 8));
        case (sz)
            2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
        logic [31:0] mask;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << (off * 8);
        return (w & ~mask) | ((d << (off * 8)) & mask);
    endfunction

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (a > 32'hFF);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_rdata, output logic [31:0] got_wd);
        exp_t e;
        int cyc, nrd, nwr;
        logic got;
        e.idx = {1'b0, a[7:2]};
        e.err = m_err(sz, a);
        e.wd = 32'h0;
        if (e.err) begin
            e.rdata = 32'h0; e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!we) begin
            e.rdata = m_load(smem[e.idx], sz, u, a[1:0]); e.lat = 3; e.nrd = 1; e.nwr = 0;
        end else begin
            e.wd = m_store(smem[e.idx], sz, a[1:0], d);
            smem[e.idx] = e.wd;
            e.rdata = 32'h0; e.nwr = 1;
            e.lat = (sz == 2'd2) ? 2 : 4;
            e.nrd = (sz == 2'd2) ? 0 : 1;
        end
        sb.push_back(e);

        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_before: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        cyc = 0; nrd = 0; nwr = 0; got = 1'b0; got_rdata = 32'h0; got_wd = 32'h0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_memread) nrd++;
            if (mem_memwrite) begin nwr++; got_wd = mem_wd; end
            if (mem_memread || mem_memwrite) begin
                vectors++;
                if (mem_addr !== e.idx) begin miscompares++; $display("FAIL mem_addr: got %0d expected %0d", mem_addr, e.idx); end
            end
            if (resp_valid) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL resp_timeout: got no resp_valid in %0d cycles expected latency %0d", cyc, e.lat);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        got_rdata = resp_rdata;
        if (cyc != e.lat) begin miscompares++; $display("FAIL latency: got %0d expected %0d", cyc, e.lat); end
        vectors++;
        if (resp_err !== e.err) begin miscompares++; $display("FAIL resp_err: got %b expected %b", resp_err, e.err); end
        vectors++;
        if (resp_rdata !== e.rdata) begin miscompares++; $display("FAIL resp_rdata: got %h expected %h", resp_rdata, e.rdata); end
        vectors++;
        if (nrd != e.nrd || nwr != e.nwr) begin
            miscompares++; $display("FAIL strobes: got rd=%0d wr=%0d expected rd=%0d wr=%0d", nrd, nwr, e.nrd, e.nwr);
        end
        if (e.nwr != 0) begin
            vectors++;
            if (got_wd !== e.wd) begin miscompares++; $display("FAIL mem_wd: got %h expected %h", got_wd, e.wd); end
        end
        // A request held during RESP must not be taken.
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ready_in_resp: got %b expected 0", req_ready); end
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err) begin
            miscompares++;
            $display("FAIL after_resp: got valid=%b ready=%b rdata=%h err=%b expected 0 1 %h %b",
                     resp_valid, req_ready, resp_rdata, resp_err, e.rdata, e.err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        vectors++;
        if (resp_valid !== 1'b0 || mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin
            miscompares++; $display("FAIL rst_strobes: got v=%b rd=%b wr=%b expected 0 0 0", resp_valid, mem_memread, mem_memwrite);
        end
        vectors++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            miscompares++; $display("FAIL rst_resp: got err=%b rdata=%h expected 0 0", resp_err, resp_rdata);
        end
        vectors++;
        if (mem_addr !== 7'd0 || mem_wd !== 32'h0) begin
            miscompares++; $display("FAIL rst_mem: got addr=%0d wd=%h expected 0 0", mem_addr, mem_wd);
        end
    endtask

    task automatic test_known_vectors();
        logic [31:0] r, w;
        do_req(1'b0, 2'd0, 1'b0, 32'h0E, 32'h0, r, w);
        vectors++;
        if (r !== 32'hFFFF_FF99) begin miscompares++; $display("FAIL lb_signed: got %h expected ffffff99", r); end
        do_req(1'b0, 2'd1, 1'b1, 32'h0C, 32'h0, r, w);
        vectors++;
        if (r !== 32'h0000_AABB) begin miscompares++; $display("FAIL lhu: got %h expected 0000aabb", r); end
        do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, r, w);
        vectors++;
        if (r !== 32'h8899_AABB) begin miscompares++; $display("FAIL lw: got %h expected 8899aabb", r); end
        do_req(1'b1, 2'd0, 1'b0, 32'h15, 32'hEE, r, w);
        vectors++;
        if (w !== 32'h1122_EE44 || r !== 32'h0) begin miscompares++; $display("FAIL sb_merge: got wd=%h rdata=%h expected 1122ee44 0", w, r); end
        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF, r, w);
        vectors++;
        if (w !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_wd: got %h expected deadbeef", w); end
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r, w);
        vectors++;
        if (r !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_readback: got %h expected deadbeef", r); end
        do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hCAFE_1234, r, w);
        vectors++;
        if (w !== 32'h1234_EE44) begin miscompares++; $display("FAIL sh_merge: got %h expected 1234ee44", w); end
    endtask

    task automatic test_errors();
        logic [31:0] r, w;
        do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, r, w);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r, w);
        do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, r, w);
        do_req(1'b1, 2'd2, 1'b0, 32'h0A, 32'h1234_5678, r, w);
        do_req(1'b1, 2'd0, 1'b0, 32'h8000_0000, 32'hFF, r, w);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, w, a;
        logic [1:0]  sz;
        for (int i = 0; i < 30; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
            if ($urandom_range(0, 15) == 0) a[9] = 1'b1;
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, r, w);
        end
    endtask

    task automatic test_reset_abort();
        int nwr;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h19; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        vectors++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            miscompares++; $display("FAIL abort_resp: got err=%b rdata=%h expected 0 0", resp_err, resp_rdata);
        end
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_memwrite || resp_valid) nwr++;
            @(negedge clk);
        end
        vectors++;
        if (nwr != 0) begin miscompares++; $display("FAIL abort_write: got %0d strobes expected 0", nwr); end
        vectors++;
        if (tmem[6] !== smem[6]) begin miscompares++; $display("FAIL abort_mem: got %h expected %h", tmem[6], smem[6]); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            tmem[i] <= 32'h0101_0101 * i ^ 32'hA5A5_0000;
            smem[i] = 32'h0101_0101 * i ^ 32'hA5A5_0000;
        end
        tmem[3] <= 32'h8899_AABB; smem[3] = 32'h8899_AABB;
        tmem[5] <= 32'h1122_3344; smem[5] = 32'h1122_3344;
        test_reset();
        test_known_vectors();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
